// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the unified memory responder
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic {
    SEL_IM,
    SEL_DM
  } sel_e;

  localparam int ADDR_LSB = 2;

endpackage

// File: rtl/mem_ctrl_sp_ram.sv
// rtl/mem_ctrl_sp_ram.sv - single-port synchronous word RAM with registered read
module sp_ram #(
  parameter int AW    = 12,
  parameter int DSize = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [DSize-1:0] wdata,
  output logic [DSize-1:0] rdata
);

  logic [DSize-1:0] mem_q [2**AW];
  logic [DSize-1:0] rdata_q;

  // Write takes the port; read data register keeps its previous value on writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IM/DM responder with programmable wait states and CPU stall
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DSize       = 32,
  parameter int AW          = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IM_enable,
  input  logic             IM_read,
  input  logic [DSize-1:0] IM_addr,
  output logic [DSize-1:0] IM_out,
  input  logic             DM_enable,
  input  logic             DM_read,
  input  logic             DM_write,
  input  logic [DSize-1:0] DM_addr,
  input  logic [DSize-1:0] DM_in,
  output logic [DSize-1:0] DM_out,
  output logic             CPU_STALL
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam int         WORD_HI  = AW + ADDR_LSB - 1;

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d;
  logic             im_pend_q, im_pend_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    im_word_q, im_word_d;
  logic [AW-1:0]    dm_word_q, dm_word_d;
  logic [DSize-1:0] dm_wdata_q, dm_wdata_d;
  logic             dm_wr_q, dm_wr_d;
  logic             im_fresh_q, im_fresh_d;
  logic             dm_fresh_q, dm_fresh_d;
  logic [DSize-1:0] im_hold_q, im_hold_d;
  logic [DSize-1:0] dm_hold_q, dm_hold_d;

  logic             im_req;
  logic             dm_req;
  logic             access;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DSize-1:0] ram_rdata;
  logic             unused_addr_bits;

  assign im_req = IM_enable & IM_read;
  assign dm_req = DM_enable & (DM_read | DM_write);

  assign access   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_we   = access && (sel_q == SEL_DM) && dm_wr_q;
  assign ram_addr = (sel_q == SEL_DM) ? dm_word_q : im_word_q;

  assign unused_addr_bits = ^{IM_addr[DSize-1:WORD_HI+1], IM_addr[ADDR_LSB-1:0],
                              DM_addr[DSize-1:WORD_HI+1], DM_addr[ADDR_LSB-1:0]};

  assign CPU_STALL = rst && ((state_q == WAIT) || ((state_q == IDLE) && (im_req || dm_req)));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    im_pend_d  = im_pend_q;
    cnt_d      = cnt_q;
    im_word_d  = im_word_q;
    dm_word_d  = dm_word_q;
    dm_wdata_d = dm_wdata_q;
    dm_wr_d    = dm_wr_q;
    case (state_q)
      IDLE: begin
        if (im_req || dm_req) begin
          state_d    = WAIT;
          sel_d      = dm_req ? SEL_DM : SEL_IM;
          im_pend_d  = im_req && dm_req;
          im_word_d  = IM_addr[WORD_HI:ADDR_LSB];
          dm_word_d  = DM_addr[WORD_HI:ADDR_LSB];
          dm_wdata_d = DM_in;
          dm_wr_d    = DM_write;
          cnt_d      = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if ((sel_q == SEL_DM) && im_pend_q) begin
          sel_d     = SEL_IM;
          im_pend_d = 1'b0;
          cnt_d     = CNT_INIT;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data shows straight from the RAM register the cycle after the access,
  // then is parked in the hold register so a later RAM read cannot disturb it.
  always_comb begin
    im_fresh_d = access && (sel_q == SEL_IM);
    dm_fresh_d = access && (sel_q == SEL_DM) && !dm_wr_q;
    im_hold_d  = im_fresh_q ? ram_rdata : im_hold_q;
    dm_hold_d  = dm_fresh_q ? ram_rdata : dm_hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_IM;
      im_pend_q  <= 1'b0;
      cnt_q      <= 4'd0;
      im_word_q  <= '0;
      dm_word_q  <= '0;
      dm_wdata_q <= '0;
      dm_wr_q    <= 1'b0;
      im_fresh_q <= 1'b0;
      dm_fresh_q <= 1'b0;
      im_hold_q  <= '0;
      dm_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      im_pend_q  <= im_pend_d;
      cnt_q      <= cnt_d;
      im_word_q  <= im_word_d;
      dm_word_q  <= dm_word_d;
      dm_wdata_q <= dm_wdata_d;
      dm_wr_q    <= dm_wr_d;
      im_fresh_q <= im_fresh_d;
      dm_fresh_q <= dm_fresh_d;
      im_hold_q  <= im_hold_d;
      dm_hold_q  <= dm_hold_d;
    end
  end

  assign IM_out = im_fresh_q ? ram_rdata : im_hold_q;
  assign DM_out = dm_fresh_q ? ram_rdata : dm_hold_q;

  sp_ram #(
    .AW   (AW),
    .DSize(DSize)
  ) u_ram (
    .clk  (clk),
    .en   (access),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(dm_wdata_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a word-array model
module tb_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IM_enable = 1'b0, IM_read = 1'b0;
  logic [31:0] IM_addr = '0;
  logic [31:0] IM_out;
  logic        DM_enable = 1'b0, DM_read = 1'b0, DM_write = 1'b0;
  logic [31:0] DM_addr = '0, DM_in = '0;
  logic [31:0] DM_out;
  logic        CPU_STALL;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [int];
  logic [31:0] exp_im = '0;
  logic [31:0] exp_dm = '0;
  int          exp_stalls;

  always #5 clk = ~clk;

  mem_ctrl #(.DSize(32), .AW(12), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_addr(IM_addr), .IM_out(IM_out),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_addr(DM_addr), .DM_in(DM_in), .DM_out(DM_out),
    .CPU_STALL(CPU_STALL)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  task automatic clear_req();
    IM_enable = 0; IM_read = 0; DM_enable = 0; DM_read = 0; DM_write = 0;
  endtask

  // Serialized DM-then-IM semantics of one request, with its expected stall length.
  task automatic model_apply(input logic ie, ir, de, dr, dw, input logic [31:0] ia, da, din);
    logic imr, dmr;
    imr = ie & ir;
    dmr = de & (dr | dw);
    if (dmr) begin
      if (dw) model[widx(da)] = din;
      else    exp_dm = model[widx(da)];
    end
    if (imr) exp_im = model[widx(ia)];
    exp_stalls = (!imr && !dmr) ? 0 : (W + 1 + ((imr && dmr) ? W : 0));
  endtask

  task automatic present(input logic ie, ir, de, dr, dw, input logic [31:0] ia, da, din);
    IM_enable = ie; IM_read = ir; IM_addr = ia;
    DM_enable = de; DM_read = dr; DM_write = dw; DM_addr = da; DM_in = din;
  endtask

  task automatic wait_done(output int stalls);
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!CPU_STALL) return;
      stalls++;
    end
  endtask

  task automatic run_op(input logic ie, ir, de, dr, dw, input logic [31:0] ia, da, din,
                        output int stalls);
    present(ie, ir, de, dr, dw, ia, da, din);
    model_apply(ie, ir, de, dr, dw, ia, da, din);
    wait_done(stalls);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_req();
  endtask

  task automatic test_reset();
    int s;
    #2 rst = 0;
    IM_enable = 1; IM_read = 1;
    repeat (3) @(negedge clk);
    checks++; if (CPU_STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", CPU_STALL); end
    checks++; if (IM_out !== 32'h0) begin errors++; $display("FAIL reset_im_out got=%h want=0", IM_out); end
    checks++; if (DM_out !== 32'h0) begin errors++; $display("FAIL reset_dm_out got=%h want=0", DM_out); end
    clear_req();
    @(posedge clk); #1 rst = 1;
    wait_done(s);
    checks++; if (s !== 0) begin errors++; $display("FAIL reset_idle stalls=%0d want=0", s); end
    @(posedge clk); #1;
  endtask

  task automatic test_dm_write_read();
    int s;
    run_op(0, 0, 1, 0, 1, 0, 32'h10, 32'hDEADBEEF, s);
    checks++; if (s !== W + 1) begin errors++; $display("FAIL wr_stalls got=%0d want=%0d", s, W + 1); end
    next_cycle();
    run_op(0, 0, 1, 1, 0, 0, 32'h10, 0, s);
    checks++; if (s !== W + 1) begin errors++; $display("FAIL rd_stalls got=%0d want=%0d", s, W + 1); end
    checks++; if (DM_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h want=deadbeef", DM_out); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    int s;
    run_op(0, 0, 1, 0, 1, 0, 32'h4, 32'h12345678, s);
    next_cycle();
    run_op(1, 1, 1, 0, 1, 32'h4, 32'h4, 32'hA5A5A5A5, s);
    checks++; if (s !== 2 * W + 1) begin errors++; $display("FAIL sim_stalls got=%0d want=%0d", s, 2 * W + 1); end
    checks++; if (IM_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL sim_im_out got=%h want=a5a5a5a5", IM_out); end
    checks++; if (DM_out !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_dm_hold got=%h want=deadbeef", DM_out); end
    next_cycle();
  endtask

  task automatic test_wrap();
    int s;
    run_op(0, 0, 1, 0, 1, 0, 32'h4000, 32'h1, s);
    next_cycle();
    run_op(0, 0, 1, 1, 0, 0, 32'h0, 0, s);
    checks++; if (DM_out !== 32'h1) begin errors++; $display("FAIL wrap_addr0 got=%h want=1", DM_out); end
    next_cycle();
    run_op(0, 0, 1, 1, 0, 0, 32'h3, 0, s);
    checks++; if (DM_out !== 32'h1) begin errors++; $display("FAIL wrap_addr3 got=%h want=1", DM_out); end
    next_cycle();
  endtask

  task automatic test_reset_mid_write();
    int s;
    run_op(0, 0, 1, 0, 1, 0, 32'h20, 32'h11111111, s);
    next_cycle();
    present(0, 0, 1, 0, 1, 0, 32'h20, 32'h0000FFFF);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++; if (CPU_STALL !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b want=0", CPU_STALL); end
    checks++; if (DM_out !== 32'h0) begin errors++; $display("FAIL midrst_dm_out got=%h want=0", DM_out); end
    clear_req();
    @(posedge clk); #1 rst = 1;
    exp_im = '0; exp_dm = '0;
    run_op(0, 0, 1, 1, 0, 0, 32'h20, 0, s);
    checks++; if (DM_out !== 32'h11111111) begin errors++; $display("FAIL midrst_word got=%h want=11111111", DM_out); end
    checks++; if (IM_out !== 32'h0) begin errors++; $display("FAIL midrst_im_out got=%h want=0", IM_out); end
    next_cycle();
  endtask

  task automatic test_stability();
    int s;
    run_op(0, 0, 1, 0, 1, 0, 32'h30, 32'hCAFEF00D, s);
    next_cycle();
    present(0, 0, 1, 1, 0, 0, 32'h30, 0);
    model_apply(0, 0, 1, 1, 0, 0, 32'h30, 0);
    s = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!CPU_STALL) break;
      s++;
      if (s > 1) begin DM_addr = $urandom; DM_in = $urandom; end
    end
    checks++; if (s !== W + 1) begin errors++; $display("FAIL stab_stalls got=%0d want=%0d", s, W + 1); end
    checks++; if (DM_out !== 32'hCAFEF00D) begin errors++; $display("FAIL stab_latched got=%h want=cafef00d", DM_out); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      DM_addr = $urandom;
      @(negedge clk);
      checks++; if (DM_out !== 32'hCAFEF00D) begin errors++; $display("FAIL stab_hold%0d got=%h want=cafef00d", k, DM_out); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          s;
    int          pool [8];
    logic        ie, ir, de, dr, dw;
    logic [31:0] ia, da;
    for (int k = 0; k < 8; k++) begin
      pool[k] = int'($urandom_range(0, 4095));
      run_op(0, 0, 1, 0, 1, 0, 32'(pool[k]) << 2, $urandom, s);
      next_cycle();
    end
    for (int n = 0; n < 40; n++) begin
      ie = 1'($urandom); ir = 1'($urandom);
      de = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      ia = ($urandom & 32'hFFFF_C003) | (32'(pool[$urandom_range(0, 7)]) << 2);
      da = ($urandom & 32'hFFFF_C003) | (32'(pool[$urandom_range(0, 7)]) << 2);
      run_op(ie, ir, de, dr, dw, ia, da, $urandom, s);
      checks++; if (s !== exp_stalls) begin errors++; $display("FAIL rand%0d_stalls got=%0d want=%0d", n, s, exp_stalls); end
      checks++; if (IM_out !== exp_im) begin errors++; $display("FAIL rand%0d_im_out got=%h want=%h", n, IM_out, exp_im); end
      checks++; if (DM_out !== exp_dm) begin errors++; $display("FAIL rand%0d_dm_out got=%h want=%h", n, DM_out, exp_dm); end
      next_cycle();
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_dm_write_read();
    test_simultaneous();
    test_wrap();
    test_reset_mid_write();
    test_stability();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
